// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the fetch requester, execute requester and
// memory-bus signals around mem_arbiter.
//   slave  : arbiter view. It takes requests and the memory response, and
//            drives the ready/data returns, the memory request and err.
//   master : environment view. It drives the requesters and the memory model.
// Fetch   : f_req, f_addr -> f_ready, f_data
// Execute : e_req, e_addr, e_we, e_wdata -> e_ready, e_data
// Memory  : mem_req, mem_we, mem_addr, mem_wdata <- mem_rdata, mem_ready
// Error   : err (one-cycle pulse on transaction timeout)
interface mem_arbiter_if;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_ready;
  logic [DW-1:0] f_data;

  logic          e_req;
  logic [AW-1:0] e_addr;
  logic          e_we;
  logic [DW-1:0] e_wdata;
  logic          e_ready;
  logic [DW-1:0] e_data;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  logic          err;

  modport slave (
    input  f_req, f_addr, e_req, e_addr, e_we, e_wdata, mem_rdata, mem_ready,
    output f_ready, f_data, e_ready, e_data, mem_req, mem_we, mem_addr,
           mem_wdata, err
  );

  modport master (
    output f_req, f_addr, e_req, e_addr, e_we, e_wdata, mem_rdata, mem_ready,
    input  f_ready, f_data, e_ready, e_data, mem_req, mem_we, mem_addr,
           mem_wdata, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates fetch reads and execute reads/writes onto a single
// registered memory bus. One transaction is in flight at a time. Every grant
// is followed by a single DONE cycle before the next grant can happen.
// Ports:
//   clk   - sole clock, rising edge
//   rst   - asynchronous, active-low reset
//   bus   - mem_arbiter_if.slave (requesters, memory bus, err)
// Parameter TIMEOUT (0..255, 0 = off): maximum cycles to wait for mem_ready.
// Optional macro MEM_ARB_RR_EN: round-robin between simultaneous requests.
//   When it is undefined, execute always wins.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;

  // Captured memory-bus command
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_cmd_t;

  state_t        state_q, state_d;
  mem_cmd_t      cmd_q, cmd_d;
  logic          mem_req_q, mem_req_d;
  logic          f_ready_q, f_ready_d;
  logic [DW-1:0] f_data_q, f_data_d;
  logic          e_ready_q, e_ready_d;
  logic [DW-1:0] e_data_q, e_data_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pick_exec_c;
  logic          timeout_c;

`ifdef MEM_ARB_RR_EN
  logic          last_exec_q, last_exec_d;

  // On a tie, the requester that did not win last time gets the bus
  assign pick_exec_c = bus.e_req && (!bus.f_req || !last_exec_q);
`else
  assign pick_exec_c = bus.e_req;
`endif

  // The current cycle is the TIMEOUT-th cycle spent waiting
  assign timeout_c = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      mem_req_q <= 1'b0;
      f_ready_q <= 1'b0;
      f_data_q  <= '0;
      e_ready_q <= 1'b0;
      e_data_q  <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
`ifdef MEM_ARB_RR_EN
      last_exec_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      mem_req_q <= mem_req_d;
      f_ready_q <= f_ready_d;
      f_data_q  <= f_data_d;
      e_ready_q <= e_ready_d;
      e_data_q  <= e_data_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
`ifdef MEM_ARB_RR_EN
      last_exec_q <= last_exec_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    mem_req_d = mem_req_q;
    f_ready_d = 1'b0;
    f_data_d  = f_data_q;
    e_ready_d = 1'b0;
    e_data_d  = e_data_q;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
`ifdef MEM_ARB_RR_EN
    last_exec_d = last_exec_q;
`endif

    case (state_q)
      IDLE: begin
        if (pick_exec_c) begin
          state_d     = EXEC;
          cmd_d.we    = bus.e_we;
          cmd_d.addr  = bus.e_addr;
          cmd_d.wdata = bus.e_wdata;
          mem_req_d   = 1'b1;
          cnt_d       = '0;
`ifdef MEM_ARB_RR_EN
          last_exec_d = 1'b1;
`endif
        end else if (bus.f_req) begin
          // Fetch leaves the write data as it was, since it is a read
          state_d    = FETCH;
          cmd_d.we   = 1'b0;
          cmd_d.addr = bus.f_addr;
          mem_req_d  = 1'b1;
          cnt_d      = '0;
`ifdef MEM_ARB_RR_EN
          last_exec_d = 1'b0;
`endif
        end
      end

      FETCH, EXEC: begin
        if (bus.mem_ready) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          if (state_q == FETCH) begin
            f_ready_d = 1'b1;
            f_data_d  = bus.mem_rdata;
          end else begin
            e_ready_d = 1'b1;
            // Writes leave the previous read data visible
            if (!cmd_q.we) begin
              e_data_d = bus.mem_rdata;
            end
          end
        end else if (timeout_c) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = cmd_q.we;
  assign bus.mem_addr  = cmd_q.addr;
  assign bus.mem_wdata = cmd_q.wdata;
  assign bus.f_ready   = f_ready_q;
  assign bus.f_data    = f_data_q;
  assign bus.e_ready   = e_ready_q;
  assign bus.e_data    = e_data_q;
  assign bus.err       = err_q;

endmodule
